// File: rtl/mbist_pkg.sv
// Shared types and widths for the MBIST memory-port arbiter.
// Port widths, the controller state encoding and a busy decode helper.
package mbist_pkg;

  localparam int ROW_W   = 10;
  localparam int COL_W   = 10;
  localparam int BANK_W  = 2;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 8;
  localparam int DRAIN_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_TEST  = 3'd2,
    ST_TERM  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == ST_DRAIN) || (s == ST_TEST) || (s == ST_TERM);
  endfunction

endpackage

// File: rtl/mbist_fault_cnt.sv
// Saturating fault counter with early-termination limit detect.
// limit_hit looks at the post-increment value so the run stops on the very cycle the limit is reached.
module mbist_fault_cnt
  import mbist_pkg::*;
#(
  parameter int FAULT_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             limit_hit
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (inc && (count_reg != '1)) begin
      count_next = count_reg + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count     = count_reg;
  assign limit_hit = (FAULT_LIMIT != 0) && (int'(count_next) >= FAULT_LIMIT);

endmodule

// File: rtl/mbist_port_ctrl.sv
// Memory port arbiter between a host and a BIST engine.
// Hands the port to BIST after a drain gap, tracks faults and reports completion/abort.
module mbist_port_ctrl
  import mbist_pkg::*;
#(
  parameter int FAULT_LIMIT  = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              test_req,
  input  logic              h_ce,
  input  logic              h_we,
  input  logic [ROW_W-1:0]  h_row,
  input  logic [COL_W-1:0]  h_col,
  input  logic [BANK_W-1:0] h_bank,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_grant,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              b_ce,
  input  logic              b_we,
  input  logic [ROW_W-1:0]  b_row,
  input  logic [COL_W-1:0]  b_col,
  input  logic [BANK_W-1:0] b_bank,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_test_end,
  input  logic              b_fault_detect,
  output logic              b_test,
  output logic              b_early_term,
  output logic [DATA_W-1:0] b_rdata,
  output logic              m_ce,
  output logic              m_we,
  output logic [ROW_W-1:0]  m_row,
  output logic [COL_W-1:0]  m_col,
  output logic [BANK_W-1:0] m_bank,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  fault_cnt
);

  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  state_t              state_reg;
  logic [DRAIN_W-1:0]  drain_cnt_reg;
  logic                aborted_reg;
  logic                rvalid_reg;
  logic [DATA_W-1:0]   rdata_hold_reg;
  logic                limit_hit;
  logic                fault_clear;
  logic                fault_inc;

  assign fault_clear = (state_reg == ST_IDLE) && test_req;
  assign fault_inc   = (state_reg == ST_TEST) && b_fault_detect;

  mbist_fault_cnt #(
    .FAULT_LIMIT (FAULT_LIMIT)
  ) u_fault_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (fault_clear),
    .inc       (fault_inc),
    .count     (fault_cnt),
    .limit_hit (limit_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      drain_cnt_reg <= '0;
      aborted_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (test_req) begin
            state_reg     <= ST_DRAIN;
            drain_cnt_reg <= '0;
            aborted_reg   <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_reg == DRAIN_LAST) begin
            state_reg     <= ST_TEST;
            drain_cnt_reg <= '0;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + DRAIN_W'(1);
          end
        end
        ST_TEST: begin
          // A normal end wins over a simultaneous abort or limit hit.
          if (b_test_end) begin
            state_reg <= ST_DONE;
          end else if (!test_req || limit_hit) begin
            state_reg   <= ST_TERM;
            aborted_reg <= 1'b1;
          end
        end
        ST_TERM: begin
          state_reg <= ST_DONE;
        end
        ST_DONE: begin
          if (!test_req) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Host read return is tracked independently so a read issued in the last
  // IDLE cycle still completes while the port is draining.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_reg     <= 1'b0;
      rdata_hold_reg <= '0;
    end else begin
      rvalid_reg <= (state_reg == ST_IDLE) && h_ce && !h_we;
      if (rvalid_reg) begin
        rdata_hold_reg <= m_rdata;
      end
    end
  end

  assign h_rvalid     = rvalid_reg;
  assign h_rdata      = rvalid_reg ? m_rdata : rdata_hold_reg;
  assign b_rdata      = m_rdata;
  assign h_grant      = (state_reg == ST_IDLE);
  assign b_test       = (state_reg == ST_TEST);
  assign b_early_term = (state_reg == ST_TERM);
  assign done         = (state_reg == ST_DONE);
  assign busy         = is_busy(state_reg);
  assign aborted      = aborted_reg;

  always_comb begin
    m_ce    = 1'b0;
    m_we    = 1'b0;
    m_row   = '0;
    m_col   = '0;
    m_bank  = '0;
    m_wdata = '0;
    case (state_reg)
      ST_IDLE: begin
        m_ce    = h_ce;
        m_we    = h_we;
        m_row   = h_row;
        m_col   = h_col;
        m_bank  = h_bank;
        m_wdata = h_wdata;
      end
      ST_TEST: begin
        m_ce    = b_ce;
        m_we    = b_we;
        m_row   = b_row;
        m_col   = b_col;
        m_bank  = b_bank;
        m_wdata = b_wdata;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mbist_port_ctrl.sv
// Directed + randomized bench for mbist_port_ctrl with a memory model and a reference store.
// Expected read data, fault counts and phase outcomes come from the bench's own bookkeeping.
module tb_mbist_port_ctrl;
  import mbist_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              test_req;
  logic              h_ce, h_we;
  logic [ROW_W-1:0]  h_row;
  logic [COL_W-1:0]  h_col;
  logic [BANK_W-1:0] h_bank;
  logic [DATA_W-1:0] h_wdata;
  logic              h_grant, h_rvalid;
  logic [DATA_W-1:0] h_rdata;
  logic              b_ce, b_we;
  logic [ROW_W-1:0]  b_row;
  logic [COL_W-1:0]  b_col;
  logic [BANK_W-1:0] b_bank;
  logic [DATA_W-1:0] b_wdata;
  logic              b_test_end, b_fault_detect;
  logic              b_test, b_early_term;
  logic [DATA_W-1:0] b_rdata;
  logic              m_ce, m_we;
  logic [ROW_W-1:0]  m_row;
  logic [COL_W-1:0]  m_col;
  logic [BANK_W-1:0] m_bank;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata = '0;
  logic              busy, done, aborted;
  logic [CNT_W-1:0]  fault_cnt;

  int pass_cnt    = 0;
  int total_cnt   = 0;
  int term_pulses = 0;
  int exp_faults  = 0;

  logic [DATA_W-1:0] mem     [int unsigned];
  logic [DATA_W-1:0] ref_mem [int unsigned];

  always #5 clk = ~clk;

  mbist_port_ctrl #(
    .FAULT_LIMIT  (8),
    .DRAIN_CYCLES (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .test_req       (test_req),
    .h_ce           (h_ce),
    .h_we           (h_we),
    .h_row          (h_row),
    .h_col          (h_col),
    .h_bank         (h_bank),
    .h_wdata        (h_wdata),
    .h_grant        (h_grant),
    .h_rvalid       (h_rvalid),
    .h_rdata        (h_rdata),
    .b_ce           (b_ce),
    .b_we           (b_we),
    .b_row          (b_row),
    .b_col          (b_col),
    .b_bank         (b_bank),
    .b_wdata        (b_wdata),
    .b_test_end     (b_test_end),
    .b_fault_detect (b_fault_detect),
    .b_test         (b_test),
    .b_early_term   (b_early_term),
    .b_rdata        (b_rdata),
    .m_ce           (m_ce),
    .m_we           (m_we),
    .m_row          (m_row),
    .m_col          (m_col),
    .m_bank         (m_bank),
    .m_wdata        (m_wdata),
    .m_rdata        (m_rdata),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .fault_cnt      (fault_cnt)
  );

  function automatic int unsigned addr_key(input logic [1:0] bk, input logic [9:0] r, input logic [9:0] c);
    return {10'd0, bk, r, c};
  endfunction

  function automatic logic [7:0] ref_rd(input int unsigned k);
    return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
  endfunction

  // Single-port memory with one-cycle read latency.
  always @(posedge clk) begin
    if (m_ce) begin
      if (m_we) begin
        mem[addr_key(m_bank, m_row, m_col)] = m_wdata;
      end else begin
        m_rdata <= mem.exists(addr_key(m_bank, m_row, m_col)) ? mem[addr_key(m_bank, m_row, m_col)] : 8'h00;
      end
    end
  end

  always @(negedge clk) begin
    if (b_early_term) term_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total_cnt++;
    assert (obs === want) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_op(input logic we, input logic [9:0] r, input logic [9:0] c,
                         input logic [1:0] bk, input logic [7:0] d);
    h_ce = 1'b1; h_we = we; h_row = r; h_col = c; h_bank = bk; h_wdata = d;
    #1;
    chk("idle_mirror_ce", 32'(m_ce), 1);
    chk("idle_mirror_we", 32'(m_we), 32'(we));
    chk("idle_mirror_addr", 32'({m_bank, m_row, m_col}), 32'({bk, r, c}));
    tick();
    h_ce = 1'b0;
    if (we) begin
      ref_mem[addr_key(bk, r, c)] = d;
      chk("host_wr_no_rvalid", 32'(h_rvalid), 0);
    end else begin
      chk("host_rvalid", 32'(h_rvalid), 1);
      chk("host_rdata", 32'(h_rdata), 32'(ref_rd(addr_key(bk, r, c))));
    end
  endtask

  // IDLE -> DRAIN -> TEST, optionally with a host read in the last IDLE cycle.
  task automatic enter_test(input bit with_read);
    int unsigned k;
    k = addr_key(2'd1, 10'd3, 10'd8);
    test_req = 1'b1;
    h_row = 10'd3; h_col = 10'd8; h_bank = 2'd1;
    h_ce = with_read; h_we = 1'b0;
    tick();
    chk("drain_grant", 32'(h_grant), 0);
    chk("drain_busy", 32'(busy), 1);
    chk("drain_fault_clr", 32'(fault_cnt), 0);
    chk("drain_abort_clr", 32'(aborted), 0);
    if (with_read) begin
      chk("drain_rvalid", 32'(h_rvalid), 1);
      chk("drain_rdata", 32'(h_rdata), 32'(ref_rd(k)));
    end
    h_ce = 1'b1; h_we = 1'b1; h_wdata = 8'h3C;
    #1;
    chk("drain1_mce", 32'(m_ce), 0);
    tick();
    chk("drain2_mce", 32'(m_ce), 0);
    chk("drain2_btest", 32'(b_test), 0);
    chk("drain2_rvalid", 32'(h_rvalid), 0);
    tick();
    chk("test_btest", 32'(b_test), 1);
    chk("test_grant", 32'(h_grant), 0);
    chk("test_busy", 32'(busy), 1);
    exp_faults = 0;
  endtask

  task automatic bist_cycle(input logic fault, input logic end_flag);
    b_ce = 1'($urandom_range(0, 1));
    b_we = 1'($urandom_range(0, 1));
    b_row = 10'($urandom_range(0, 3));
    b_col = 10'($urandom_range(0, 1));
    b_bank = 2'($urandom_range(0, 1));
    b_wdata = 8'($urandom);
    b_fault_detect = fault;
    b_test_end = end_flag;
    #1;
    chk("test_mirror_ce", 32'(m_ce), 32'(b_ce));
    chk("test_mirror_addr", 32'({m_bank, m_row, m_col, m_we}), 32'({b_bank, b_row, b_col, b_we}));
    chk("test_mirror_wdata", 32'(m_wdata), 32'(b_wdata));
    tick();
    if (b_ce && b_we) ref_mem[addr_key(b_bank, b_row, b_col)] = b_wdata;
    if (b_ce && !b_we) chk("bist_rdata", 32'(b_rdata), 32'(ref_rd(addr_key(b_bank, b_row, b_col))));
    if (fault) exp_faults = (exp_faults < 255) ? exp_faults + 1 : 255;
    chk("fault_cnt", 32'(fault_cnt), exp_faults);
    b_test_end = 1'b0;
  endtask

  task automatic back_to_idle();
    h_ce = 1'b0; b_ce = 1'b0; b_fault_detect = 1'b0; b_test_end = 1'b0;
    test_req = 1'b0;
    tick();
    tick();
    chk("idle_grant", 32'(h_grant), 1);
    chk("idle_done", 32'(done), 0);
  endtask

  initial begin
    logic [9:0] fmask;
    int         t0;
    rst = 1'b0; test_req = 1'b0;
    h_ce = 1'b0; h_we = 1'b0; h_row = '0; h_col = '0; h_bank = '0; h_wdata = '0;
    b_ce = 1'b0; b_we = 1'b0; b_row = '0; b_col = '0; b_bank = '0; b_wdata = '0;
    b_test_end = 1'b0; b_fault_detect = 1'b0;
    #2;
    chk("rst_grant", 32'(h_grant), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_aborted", 32'(aborted), 0);
    chk("rst_fault_cnt", 32'(fault_cnt), 0);
    chk("rst_rvalid", 32'(h_rvalid), 0);
    chk("rst_rdata", 32'(h_rdata), 0);
    chk("rst_btest", 32'(b_test), 0);
    chk("rst_early_term", 32'(b_early_term), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Idle host access
    host_op(1'b1, 10'd3, 10'd8, 2'd1, 8'hA5);
    host_op(1'b0, 10'd3, 10'd8, 2'd1, 8'h00);
    tick();
    chk("rvalid_drop", 32'(h_rvalid), 0);
    chk("rdata_hold", 32'(h_rdata), 32'hA5);
    for (int i = 0; i < 24; i++) begin
      host_op(1'($urandom_range(0, 1)), 10'($urandom_range(0, 3)), 10'($urandom_range(0, 1)),
              2'($urandom_range(0, 1)), 8'($urandom));
    end

    // Clean completion with exactly three fault cycles
    enter_test(1'b1);
    fmask = '0;
    while ($countones(fmask) < 3) fmask[$urandom_range(0, 9)] = 1'b1;
    for (int i = 0; i < 10; i++) bist_cycle(fmask[i], 1'b0);
    bist_cycle(1'b0, 1'b1);
    b_ce = 1'b1;
    #1;
    chk("clean_done", 32'(done), 1);
    chk("clean_aborted", 32'(aborted), 0);
    chk("clean_fault_cnt", 32'(fault_cnt), 3);
    chk("clean_busy", 32'(busy), 0);
    chk("done_mce", 32'(m_ce), 0);
    tick();
    chk("done_hold", 32'(done), 1);
    back_to_idle();
    chk("idle_fault_hold", 32'(fault_cnt), 3);
    host_op(1'b0, 10'd3, 10'd8, 2'd1, 8'h00);

    // Fault limit reached
    enter_test(1'b0);
    t0 = term_pulses;
    for (int i = 0; i < 8; i++) bist_cycle(1'b1, 1'b0);
    b_ce = 1'b1;
    #1;
    chk("limit_term", 32'(b_early_term), 1);
    chk("limit_btest", 32'(b_test), 0);
    chk("limit_busy", 32'(busy), 1);
    chk("limit_aborted", 32'(aborted), 1);
    chk("term_mce", 32'(m_ce), 0);
    tick();
    chk("limit_done", 32'(done), 1);
    chk("limit_term_off", 32'(b_early_term), 0);
    chk("limit_fault_cnt", 32'(fault_cnt), 8);
    chk("limit_term_pulses", 32'(term_pulses - t0), 1);
    back_to_idle();

    // Host abort mid-test
    enter_test(1'b0);
    t0 = term_pulses;
    bist_cycle(1'b0, 1'b0);
    bist_cycle(1'b0, 1'b0);
    test_req = 1'b0; h_ce = 1'b0; b_ce = 1'b0;
    tick();
    chk("abort_term", 32'(b_early_term), 1);
    chk("abort_aborted", 32'(aborted), 1);
    tick();
    chk("abort_done", 32'(done), 1);
    chk("abort_aborted_done", 32'(aborted), 1);
    tick();
    chk("abort_idle_grant", 32'(h_grant), 1);
    chk("abort_term_pulses", 32'(term_pulses - t0), 1);

    // Test end coinciding with the limit hit
    enter_test(1'b0);
    t0 = term_pulses;
    for (int i = 0; i < 7; i++) bist_cycle(1'b1, 1'b0);
    bist_cycle(1'b1, 1'b1);
    chk("tie_done", 32'(done), 1);
    chk("tie_aborted", 32'(aborted), 0);
    chk("tie_term_pulses", 32'(term_pulses - t0), 0);
    back_to_idle();

    // Reset in the middle of a test
    enter_test(1'b0);
    t0 = term_pulses;
    bist_cycle(1'b1, 1'b0);
    h_ce = 1'b0; b_ce = 1'b1; b_we = 1'b0;
    #1;
    chk("pre_rst_mce", 32'(m_ce), 1);
    rst = 1'b0;
    #1;
    chk("mrst_btest", 32'(b_test), 0);
    chk("mrst_mce", 32'(m_ce), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_fault_cnt", 32'(fault_cnt), 0);
    chk("mrst_rvalid", 32'(h_rvalid), 0);
    chk("mrst_rdata", 32'(h_rdata), 0);
    chk("mrst_early_term", 32'(b_early_term), 0);
    chk("mrst_grant", 32'(h_grant), 1);
    tick();
    tick();
    chk("mrst_no_term_pulse", 32'(term_pulses - t0), 0);
    test_req = 1'b0; b_ce = 1'b0;
    rst = 1'b1;
    tick();
    chk("post_rst_grant", 32'(h_grant), 1);
    chk("post_rst_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mbist_port_ctrl.md
MBIST_PORT_CTRL -- requirements
Module: mbist_port_ctrl

Interface
REQ-001 Parameter FAULT_LIMIT, default 8, sets the fault count that triggers early termination; 0 disables early termination.
REQ-002 Parameter DRAIN_CYCLES, default 2, sets the idle cycles between revoking host access and handing the port to BIST (range 1..15).
REQ-003 Port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst, input, 1, reset, asynchronous and active-low.
REQ-005 Port test_req, input, 1, host request to run BIST; level-sensitive.
REQ-006 Ports h_ce, h_we, h_row[9:0], h_col[9:0], h_bank[1:0], h_wdata[7:0], input, are the host memory request.
REQ-007 Ports h_grant (1), h_rvalid (1), h_rdata[7:0], output, are the host grant, read-valid and read data.
REQ-008 Ports b_ce, b_we, b_row[9:0], b_col[9:0], b_bank[1:0], b_wdata[7:0], b_test_end, b_fault_detect, input, come from the BIST engine.
REQ-009 Ports b_test (1), b_early_term (1), b_rdata[7:0], output, go to the BIST engine.
REQ-010 Ports m_ce, m_we, m_row[9:0], m_col[9:0], m_bank[1:0], m_wdata[7:0], output, drive the memory; m_rdata[7:0] is the memory read data input.
REQ-011 Ports busy (1), done (1), aborted (1), fault_cnt[7:0], output, are status.

Function
REQ-012 FSM states SHALL be IDLE, DRAIN, TEST, TERM and DONE.
REQ-013 IDLE: h_grant=1 and the m_* outputs mirror the h_* inputs combinationally; test_req=1 SHALL move to DRAIN, clear fault_cnt and clear aborted.
REQ-014 DRAIN: h_grant=0, m_ce=0, and a counter runs DRAIN_CYCLES cycles before moving to TEST.
REQ-015 TEST: b_test=1 and m_* mirror b_* combinationally; host h_ce SHALL be ignored.
REQ-016 TEST transitions, in priority order:
- b_test_end=1 -> DONE.
- test_req=0 -> TERM with aborted=1.
- fault_cnt reaching FAULT_LIMIT (FAULT_LIMIT!=0) -> TERM with aborted=1.
REQ-017 TERM: b_early_term=1 and b_test=0 for exactly one cycle, m_ce=0, then DONE.
REQ-018 DONE: done=1 and m_ce=0; test_req=0 SHALL return to IDLE on the next cycle.
REQ-019 busy SHALL be 1 in DRAIN, TEST and TERM, and 0 otherwise.
REQ-020 fault_cnt SHALL increment by 1 on each TEST cycle with b_fault_detect=1, saturate at 255, and hold its value in DONE until the next IDLE->DRAIN transition.
REQ-021 Memory read latency is one cycle: m_rdata is valid the cycle after m_ce=1 with m_we=0.
REQ-022 h_rvalid SHALL pulse 1 cycle after an accepted host read (IDLE, h_ce=1, h_we=0), with h_rdata=m_rdata; otherwise h_rvalid=0 and h_rdata holds its last value.
REQ-023 b_rdata SHALL equal m_rdata at all times.
REQ-024 A host read accepted in the last IDLE cycle SHALL still return h_rvalid during DRAIN.
REQ-025 b_test_end and a limit hit in the same cycle SHALL resolve to DONE with aborted=0.

Reset
REQ-026 On rst=0 the block SHALL asynchronously enter IDLE, with drain counter=0, fault_cnt=0, aborted=0, h_rvalid=0, h_rdata=0, b_test=0, b_early_term=0, done=0 and busy=0.
REQ-027 Reset asserted mid-TEST SHALL drop b_test and m_ce immediately, without issuing an early_term pulse.

Structure
REQ-028 FSM state encodings and the 10/10/2/8 address/data widths SHALL live in a shared package, mbist_pkg.
REQ-029 The fault counter with saturation and limit compare SHALL be a sub-module, mbist_fault_cnt; the FSM and muxes SHALL stay in the top.

Verification
REQ-030 Idle host access: host writes 0xA5 at row 3/col 8/bank 01, then reads it -> h_rvalid=1 one cycle after the read, with h_rdata=0xA5.
REQ-031 Handover: test_req rises -> h_grant=0 the next cycle, m_ce=0 for 2 cycles, then b_test=1 and m_* tracks b_*.
REQ-032 Clean completion with 3 fault cycles and then b_test_end -> done=1, aborted=0, fault_cnt=3; test_req=0 -> IDLE with h_grant=1.
REQ-033 Limit hit: 8 consecutive b_fault_detect cycles -> b_early_term=1 for 1 cycle, then done=1, aborted=1, fault_cnt=8.
REQ-034 Abort: test_req=0 mid-TEST -> TERM pulse, aborted=1, DONE, then IDLE.
REQ-035 Reset: rst=0 mid-TEST -> all outputs at reset values within the same cycle, with no b_early_term pulse.
